s00_axis_rx_fifo: RTL and testbench



---
 rtl/s00_axis_rx_fifo_pkg.sv | 9 +
 rtl/s00_axis_rx_fifo_if.sv | 12 +
 rtl/s00_axis_rx_fifo_sync_fifo_core.sv | 70 +++++++
 rtl/s00_axis_rx_fifo.sv | 62 ++++++
 tb/tb_s00_axis_rx_fifo.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/s00_axis_rx_fifo_pkg.sv
// s00_axis_rx_fifo_pkg: shared defaults and pointer-width helper for the stream FIFOs
package s00_axis_rx_fifo_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 16;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/s00_axis_rx_fifo_if.sv
// s00_axis_rx_fifo_if: AXI4-Stream beat bundle (tdata/tstrb/tvalid/tready/tlast/tuser)
// master drives the beat and samples tready; slave does the reverse.
interface s00_axis_rx_fifo_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic                tvalid;
    logic                tready;
    logic                tlast;
    logic                tuser;
    modport master (output tdata, tstrb, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tstrb, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/s00_axis_rx_fifo_sync_fifo_core.sv
// sync_fifo_core: circular FIFO storing data/last/user with a registered read port
// in: clk, rst_n, wr_en + wr_data/wr_last/wr_user, rd_en
// out: rd_data/rd_last/rd_user/rd_valid (one cycle after a pop), count, empty, full
module sync_fifo_core
    import s00_axis_rx_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    wr_last,
    input  logic                    wr_user,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_last,
    output logic                    rd_user,
    output logic                    rd_valid,
    output logic [ptr_w(DEPTH):0]   count,
    output logic                    empty,
    output logic                    full
);
    localparam int PW = ptr_w(DEPTH);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic              mem_last [DEPTH];
    logic              mem_user [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign empty = count == '0;
    assign full  = count == (PW+1)'(DEPTH);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_data[wr_ptr] <= wr_data;
            mem_last[wr_ptr] <= wr_last;
            mem_user[wr_ptr] <= wr_user;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
            rd_user  <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + PW'(do_wr);
            rd_ptr   <= rd_ptr + PW'(do_rd);
            count    <= count + (PW+1)'(do_wr) - (PW+1)'(do_rd);
            rd_valid <= do_rd;
            if (do_rd) begin
                rd_data <= mem_data[rd_ptr];
                rd_last <= mem_last[rd_ptr];
                rd_user <= mem_user[rd_ptr];
            end
        end
    end
endmodule

// File: rtl/s00_axis_rx_fifo.sv
// s00_axis_rx_fifo: AXI4-Stream slave receive buffer feeding the crop core via rd_en
// in: S_AXIS_ACLK, S_AXIS_ARESETN, s_axis (slave beat bundle), rd_en
// out: data_out/last_out/user_out/valid_out, empty, fill_level, sticky underflow
module s00_axis_rx_fifo
    import s00_axis_rx_fifo_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = DEF_DATA_W,
    parameter int C_S_AXIS_FIFO_DEPTH  = DEF_DEPTH
) (
    input  logic                                  S_AXIS_ACLK,
    input  logic                                  S_AXIS_ARESETN,
    s00_axis_rx_fifo_if.slave                     s_axis,
    input  logic                                  rd_en,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]       data_out,
    output logic                                  last_out,
    output logic                                  user_out,
    output logic                                  valid_out,
    output logic                                  empty,
    output logic [ptr_w(C_S_AXIS_FIFO_DEPTH):0]   fill_level,
    output logic                                  underflow
);
    logic run_q;
    logic full;
    logic accept;
    logic unused_tstrb;

    // tready is held low in reset and in the release cycle; afterwards it is a
    // pure decode of the registered count, so no input reaches it combinationally.
    assign s_axis.tready = run_q && !full;
    assign accept        = s_axis.tvalid && s_axis.tready;
    assign unused_tstrb  = ^s_axis.tstrb;

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            run_q     <= 1'b0;
            underflow <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
    end

    sync_fifo_core #(
        .DATA_W (C_S_AXIS_TDATA_WIDTH),
        .DEPTH  (C_S_AXIS_FIFO_DEPTH)
    ) u_core (
        .clk      (S_AXIS_ACLK),
        .rst_n    (S_AXIS_ARESETN),
        .wr_en    (accept),
        .wr_data  (s_axis.tdata),
        .wr_last  (s_axis.tlast),
        .wr_user  (s_axis.tuser),
        .rd_en    (rd_en),
        .rd_data  (data_out),
        .rd_last  (last_out),
        .rd_user  (user_out),
        .rd_valid (valid_out),
        .count    (fill_level),
        .empty    (empty),
        .full     (full)
    );
endmodule

// File: tb/tb_s00_axis_rx_fifo.sv
// tb_s00_axis_rx_fifo: directed and random checks of the AXIS receive FIFO
module tb_s00_axis_rx_fifo;
    localparam int W = 32;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] data_out;
    logic         last_out, user_out, valid_out, empty, underflow;
    logic [4:0]   fill_level;

    s00_axis_rx_fifo_if #(.DATA_W(W)) s_axis();

    s00_axis_rx_fifo #(.C_S_AXIS_TDATA_WIDTH(W), .C_S_AXIS_FIFO_DEPTH(D)) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rst_n),
        .s_axis         (s_axis),
        .rd_en          (rd_en),
        .data_out       (data_out),
        .last_out       (last_out),
        .user_out       (user_out),
        .valid_out      (valid_out),
        .empty          (empty),
        .fill_level     (fill_level),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W+1:0] m_q[$];
    logic         m_run = 1'b0;
    logic         m_under = 1'b0;
    logic         m_valid = 1'b0;
    logic [W+1:0] m_out = '0;

    task automatic drive(input logic v, input logic [W-1:0] d, input logic l, input logic u, input logic r);
        s_axis.tvalid = v;
        s_axis.tdata  = d;
        s_axis.tlast  = l;
        s_axis.tuser  = u;
        s_axis.tstrb  = '1;
        rd_en         = r;
    endtask

    // Advance one clock, updating the reference queue from the inputs on the bus.
    task automatic tick();
        bit acc, pop;
        acc = s_axis.tvalid && m_run && m_q.size() != D;
        pop = rd_en && m_q.size() != 0;
        if (rd_en && m_q.size() == 0) m_under = 1'b1;
        m_valid = pop;
        if (pop) m_out = m_q.pop_front();
        if (acc) m_q.push_back({s_axis.tuser, s_axis.tlast, s_axis.tdata});
        m_run = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        m_q.delete();
        m_run = 1'b0; m_under = 1'b0; m_valid = 1'b0; m_out = '0;
        #1;
        checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %0b exp 0", s_axis.tready); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", empty); end
        checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill_level); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid_out); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", data_out); end
        checks++; if ({last_out, user_out} !== 2'b00) begin errors++; $display("FAIL reset_last_user got %b exp 00", {last_out, user_out}); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %0b exp 0", underflow); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL release_beat_taken fill got %0d exp 0", fill_level); end
        checks++; if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL release_tready got %0b exp 1", s_axis.tready); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_basic();
        int nv = 0;
        for (int c = 0; c < 9; c++) begin
            drive(c < 5, 32'(32'h10 + c), c == 4, c == 0, c >= 1 && c <= 5);
            tick();
            checks++; if (valid_out !== (c >= 1 && c <= 5)) begin errors++; $display("FAIL basic_valid c=%0d got %0b", c, valid_out); end
            if (valid_out) begin
                checks++;
                if (data_out !== 32'(32'h10 + nv) || user_out !== (nv == 0) || last_out !== (nv == 4)) begin
                    errors++; $display("FAIL basic_beat %0d got %h/%0b/%0b exp %h", nv, data_out, last_out, user_out, 32'(32'h10 + nv));
                end
                nv++;
            end
        end
        checks++; if (nv != 5) begin errors++; $display("FAIL basic_count got %0d exp 5", nv); end
        checks++; if (fill_level !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL basic_drained fill %0d empty %0b exp 0/1", fill_level, empty); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL basic_underflow got %0b exp 0", underflow); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(32'h100 + i), 1'b0, 1'b0, 1'b0);
            tick();
            checks++; if (fill_level !== 5'(i + 1) || s_axis.tready !== (i < 15)) begin errors++; $display("FAIL full_fill i=%0d fill %0d tready %0b", i, fill_level, s_axis.tready); end
        end
        drive(1'b1, 32'h1FF, 1'b1, 1'b0, 1'b0);
        repeat (3) begin
            tick();
            checks++; if (fill_level !== 5'd16 || s_axis.tready !== 1'b0) begin errors++; $display("FAIL full_hold fill %0d tready %0b exp 16/0", fill_level, s_axis.tready); end
        end
        drive(1'b1, 32'h1FF, 1'b1, 1'b0, 1'b1);
        tick();
        checks++; if (fill_level !== 5'd15 || s_axis.tready !== 1'b1) begin errors++; $display("FAIL full_pop fill %0d tready %0b exp 15/1", fill_level, s_axis.tready); end
        checks++; if (valid_out !== 1'b1 || data_out !== 32'h100) begin errors++; $display("FAIL full_pop_data got %0b/%h exp 1/100", valid_out, data_out); end
        drive(1'b1, 32'h1FF, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (fill_level !== 5'd16 || s_axis.tready !== 1'b0) begin errors++; $display("FAIL full_refill fill %0d tready %0b exp 16/0", fill_level, s_axis.tready); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if (valid_out !== 1'b1 || data_out !== (k < 16 ? 32'(32'h100 + k) : 32'h1FF) || last_out !== (k == 16)) begin
                errors++; $display("FAIL full_drain k=%0d got %0b/%h/%0b", k, valid_out, data_out, last_out);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (empty !== 1'b1 || valid_out !== 1'b0) begin errors++; $display("FAIL full_empty got %0b/%0b exp 1/0", empty, valid_out); end
    endtask

    task automatic test_stream();
        for (int c = 0; c <= 40; c++) begin
            drive(c < 40, 32'(32'h200 + c), c == 39, c == 0, c >= 1);
            tick();
            checks++; if (s_axis.tready !== 1'b1 || fill_level !== 5'(c < 40)) begin errors++; $display("FAIL stream_fill c=%0d fill %0d tready %0b", c, fill_level, s_axis.tready); end
            checks++;
            if (valid_out !== (c >= 1) || (c >= 1 && data_out !== 32'(32'h200 + c - 1))) begin
                errors++; $display("FAIL stream_beat c=%0d got %0b/%h", c, valid_out, data_out);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL stream_underflow got %0b exp 0", underflow); end
    endtask

    task automatic test_underflow();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (underflow !== 1'b1 || valid_out !== 1'b0 || fill_level !== 5'd0) begin errors++; $display("FAIL under_set got %0b/%0b/%0d exp 1/0/0", underflow, valid_out, fill_level); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL under_sticky got %0b exp 1", underflow); end
        drive(1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
        tick();
        checks++; if (fill_level !== 5'd1 || valid_out !== 1'b0) begin errors++; $display("FAIL under_wr_empty fill %0d valid %0b exp 1/0", fill_level, valid_out); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (valid_out !== 1'b1 || data_out !== 32'h300 || {last_out, user_out} !== 2'b11) begin errors++; $display("FAIL under_readback got %0b/%h exp 1/300", valid_out, data_out); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 1000; c++) begin
            drive(c < 500 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  c < 500 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            tick();
            checks++;
            if (valid_out !== m_valid || (m_valid && {user_out, last_out, data_out} !== m_out)) begin
                errors++; $display("FAIL rand_out c=%0d got %0b/%h exp %0b/%h", c, valid_out, {user_out, last_out, data_out}, m_valid, m_out);
            end
            checks++;
            if (fill_level !== 5'(m_q.size()) || empty !== (m_q.size() == 0) || s_axis.tready !== (m_q.size() != D) || underflow !== m_under) begin
                errors++; $display("FAIL rand_state c=%0d fill %0d exp %0d tready %0b under %0b exp %0b", c, fill_level, m_q.size(), s_axis.tready, underflow, m_under);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        test_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'(32'h400 + i), 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (fill_level !== 5'd8 || data_out !== 32'h400 || user_out !== 1'b1) begin errors++; $display("FAIL mid_prefill fill %0d data %h exp 8/400", fill_level, data_out); end
        #2;
        test_reset();
        drive(1'b1, 32'hABC, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (valid_out !== 1'b1 || data_out !== 32'hABC || {last_out, user_out} !== 2'b10) begin errors++; $display("FAIL mid_first_beat got %0b/%h exp 1/abc", valid_out, data_out); end
        checks++; if (empty !== 1'b1 || fill_level !== 5'd0) begin errors++; $display("FAIL mid_empty got %0b/%0d exp 1/0", empty, fill_level); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_stream();
        test_underflow();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
